// File: rtl/k_and_s_pkg.sv
// Shared types for the K-and-S control unit: decoded opcodes, FSM states,
// ALU operation codes and the bundle of datapath control outputs.
package k_and_s_pkg;

    typedef enum logic [3:0] {
        I_NOP,
        I_LOAD,
        I_STORE,
        I_MOVE,
        I_ADD,
        I_SUB,
        I_AND,
        I_OR,
        I_BRANCH,
        I_BZERO,
        I_BNZERO,
        I_BNEG,
        I_BNNEG,
        I_BOV,
        I_BNOV,
        I_HALT
    } decoded_instruction_type;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        LOAD,
        ALU_WB,
        STORE,
        BRANCH,
        HALTED,
        FAULT
    } ctrl_state_t;

    localparam logic [1:0] OP_OR  = 2'b00;
    localparam logic [1:0] OP_ADD = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    // All controls the FSM produces in one cycle; cleared to zero by default.
    typedef struct packed {
        logic       branch;
        logic       pc_enable;
        logic       ir_enable;
        logic       write_reg_enable;
        logic       addr_sel;
        logic       c_sel;
        logic       flags_reg_enable;
        logic       ram_write_enable;
        logic [1:0] operation;
        logic       mem_req;
        logic       halt;
        logic       fault;
    } ctrl_out_t;

    // States that wait on the memory and are therefore guarded by the timer.
    function automatic logic is_mem_state(ctrl_state_t s);
        return (s == FETCH) || (s == LOAD) || (s == STORE);
    endfunction

endpackage

// File: rtl/ks_ctrl_unit_p_if.sv
// Control-unit <-> datapath/memory bundle.
// Memory handshake: mem_req is held high for the whole access and the
// address/write controls stay stable with it; the access completes in the
// cycle where mem_req and mem_ready are both high, and mem_req may drop (or
// a new access start) from the next cycle on.
interface ks_ctrl_unit_p_if;
    import k_and_s_pkg::*;

    decoded_instruction_type decoded_instruction;
    logic       zero_op;
    logic       neg_op;
    logic       unsigned_overflow;
    logic       signed_overflow;
    logic       mem_ready;
    logic       mem_req;
    logic       branch;
    logic       pc_enable;
    logic       ir_enable;
    logic       write_reg_enable;
    logic       addr_sel;
    logic       c_sel;
    logic       flags_reg_enable;
    logic       ram_write_enable;
    logic [1:0] operation;

    modport master (
        input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, mem_ready,
        output mem_req, branch, pc_enable, ir_enable, write_reg_enable,
               addr_sel, c_sel, flags_reg_enable, ram_write_enable, operation
    );

    modport slave (
        output decoded_instruction, zero_op, neg_op, unsigned_overflow,
               signed_overflow, mem_ready,
        input  mem_req, branch, pc_enable, ir_enable, write_reg_enable,
               addr_sel, c_sel, flags_reg_enable, ram_write_enable, operation
    );
endinterface

// File: rtl/ks_wait_timer.sv
// Counts consecutive cycles a memory state spends without mem_ready and
// flags the cycle in which that count reaches the limit (limit 0 = never).
module ks_wait_timer #(
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         tick,
    input  logic [W-1:0] limit,
    output logic         expired
);
    logic [W-1:0] cnt_q;
    logic [W:0]   cnt_inc;

    assign cnt_inc = {1'b0, cnt_q} + {{W{1'b0}}, 1'b1};
    // This tick is the limit-th waiting cycle of the current access.
    assign expired = tick && (limit != '0) && (cnt_inc >= {1'b0, limit});

    // Wait counter: clear on state change, otherwise count waiting cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_inc[W-1:0];
        end
    end
endmodule

// File: rtl/ks_ctrl_unit_p.sv
// Multi-cycle control unit: fetch/decode FSM driving the datapath and a
// handshaked memory, with a wait timeout, halt/resume and a retire counter.
module ks_ctrl_unit_p
    import k_and_s_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int WAIT_LIMIT    = 16,
    parameter int OV_SIGNED     = 0,
    parameter int CNT_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    ks_ctrl_unit_p_if.master    bus,
    input  logic                resume,
    output logic                halt,
    output logic                fault,
    output logic [CNT_W-1:0]    instr_count,
    output ctrl_state_t         state_dbg
);
    localparam int WT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    ctrl_state_t      state_q, state_d;
    logic [1:0]       op_q, op_d;
    logic [CNT_W-1:0] count_q;
    ctrl_out_t        ctl;
    logic             mem_rdy;
    logic             ovf;
    logic             wait_tick;
    logic             wait_clear;
    logic             wait_expired;

    assign mem_rdy = (MEM_HANDSHAKE != 0) ? bus.mem_ready : 1'b1;
    assign ovf     = (OV_SIGNED != 0) ? bus.signed_overflow : bus.unsigned_overflow;

    // The timer restarts whenever the state changes, so every entry into a
    // memory state begins from zero.
    assign wait_tick  = is_mem_state(state_q) && !mem_rdy;
    assign wait_clear = (state_d != state_q);

    ks_wait_timer #(.W(WT_W)) u_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .tick    (wait_tick),
        .limit   (WT_W'(WAIT_LIMIT)),
        .expired (wait_expired)
    );

    // State and latched ALU operation registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= OP_OR;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    // Next state and per-state controls; mem_ready wins over the timeout.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ctl     = '0;
        case (state_q)
            FETCH: begin
                ctl.mem_req = 1'b1;
                if (mem_rdy) begin
                    ctl.ir_enable = 1'b1;
                    ctl.pc_enable = 1'b1;
                    state_d       = DECODE;
                end else if (wait_expired) begin
                    state_d = FAULT;
                end
            end
            DECODE: begin
                case (bus.decoded_instruction)
                    I_OR, I_ADD, I_SUB, I_AND: begin
                        case (bus.decoded_instruction)
                            I_ADD:   op_d = OP_ADD;
                            I_SUB:   op_d = OP_SUB;
                            I_AND:   op_d = OP_AND;
                            default: op_d = OP_OR;
                        endcase
                        ctl.operation        = op_d;
                        ctl.flags_reg_enable = 1'b1;
                        state_d              = ALU_WB;
                    end
                    I_MOVE: begin
                        op_d    = OP_OR;
                        state_d = ALU_WB;
                    end
                    I_LOAD:   state_d = LOAD;
                    I_STORE:  state_d = STORE;
                    I_BRANCH: state_d = BRANCH;
                    I_HALT:   state_d = HALTED;
                    I_BZERO:  state_d = bus.zero_op ? BRANCH : FETCH;
                    I_BNZERO: state_d = bus.zero_op ? FETCH : BRANCH;
                    I_BNEG:   state_d = bus.neg_op ? BRANCH : FETCH;
                    I_BNNEG:  state_d = bus.neg_op ? FETCH : BRANCH;
                    I_BOV:    state_d = ovf ? BRANCH : FETCH;
                    I_BNOV:   state_d = ovf ? FETCH : BRANCH;
                    default:  state_d = FETCH;
                endcase
            end
            ALU_WB: begin
                ctl.c_sel            = 1'b1;
                ctl.write_reg_enable = 1'b1;
                ctl.operation        = op_q;
                state_d              = FETCH;
            end
            LOAD: begin
                ctl.addr_sel = 1'b1;
                ctl.mem_req  = 1'b1;
                if (mem_rdy) begin
                    ctl.write_reg_enable = 1'b1;
                    state_d              = FETCH;
                end else if (wait_expired) begin
                    state_d = FAULT;
                end
            end
            STORE: begin
                ctl.addr_sel         = 1'b1;
                ctl.mem_req          = 1'b1;
                ctl.ram_write_enable = 1'b1;
                if (mem_rdy) begin
                    state_d = FETCH;
                end else if (wait_expired) begin
                    state_d = FAULT;
                end
            end
            BRANCH: begin
                ctl.branch    = 1'b1;
                ctl.pc_enable = 1'b1;
                ctl.addr_sel  = 1'b1;
                state_d       = FETCH;
            end
            HALTED: begin
                ctl.halt = 1'b1;
                if (resume) begin
                    state_d = FETCH;
                end
            end
            FAULT: begin
                ctl.halt  = 1'b1;
                ctl.fault = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Retire counter: an instruction retires when control returns to FETCH
    // from any execute state; leaving HALTED is not a retirement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (state_d == FETCH && state_q != FETCH && state_q != HALTED) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign bus.mem_req          = ctl.mem_req;
    assign bus.branch           = ctl.branch;
    assign bus.pc_enable        = ctl.pc_enable;
    assign bus.ir_enable        = ctl.ir_enable;
    assign bus.write_reg_enable = ctl.write_reg_enable;
    assign bus.addr_sel         = ctl.addr_sel;
    assign bus.c_sel            = ctl.c_sel;
    assign bus.flags_reg_enable = ctl.flags_reg_enable;
    assign bus.ram_write_enable = ctl.ram_write_enable;
    assign bus.operation        = ctl.operation;
    assign halt                 = ctl.halt;
    assign fault                = ctl.fault;
    assign instr_count          = count_q;
    assign state_dbg            = state_q;
endmodule

// File: tb/tb_ks_ctrl_unit_p.sv
// Bench for ks_ctrl_unit_p: two parameterisations driven cycle by cycle with
// directed vectors; every driven cycle queues the expected controls and
// count, and a negedge monitor pops and compares them.
module tb_ks_ctrl_unit_p;
    import k_and_s_pkg::*;

    localparam int W = 29;

    // Control masks: {branch,pc,ir,wr,addr_sel,c_sel,flags,ram_we,op[1:0],mem_req,halt,fault}
    localparam logic [12:0] NONE = 13'h0000;
    localparam logic [12:0] BR   = 13'h1000;
    localparam logic [12:0] PC   = 13'h0800;
    localparam logic [12:0] IR   = 13'h0400;
    localparam logic [12:0] WR   = 13'h0200;
    localparam logic [12:0] AS   = 13'h0100;
    localparam logic [12:0] CS   = 13'h0080;
    localparam logic [12:0] FL   = 13'h0040;
    localparam logic [12:0] RW   = 13'h0020;
    localparam logic [12:0] OADD = 13'h0008;
    localparam logic [12:0] OSUB = 13'h0010;
    localparam logic [12:0] OAND = 13'h0018;
    localparam logic [12:0] MR   = 13'h0004;
    localparam logic [12:0] HT   = 13'h0002;
    localparam logic [12:0] FT   = 13'h0001;

    // Flag inputs: {zero_op, neg_op, unsigned_overflow, signed_overflow}
    localparam logic [3:0] F_0   = 4'b0000;
    localparam logic [3:0] F_Z   = 4'b1000;
    localparam logic [3:0] F_N   = 4'b0100;
    localparam logic [3:0] F_UOV = 4'b0010;
    localparam logic [3:0] F_SOV = 4'b0001;

    typedef struct packed {
        decoded_instruction_type ins;
        logic [3:0]              flg;
        logic                    taken;
    } br_vec_t;

    // Conditional-branch vectors for the OV_SIGNED=1 instance.
    br_vec_t br_tab [10] = '{
        '{I_BOV,    F_SOV, 1'b1},
        '{I_BOV,    F_UOV, 1'b0},
        '{I_BZERO,  F_0,   1'b0},
        '{I_BNZERO, F_0,   1'b1},
        '{I_BNEG,   F_N,   1'b1},
        '{I_BNNEG,  F_N,   1'b0},
        '{I_BZERO,  F_Z,   1'b1},
        '{I_BNOV,   F_SOV, 1'b0},
        '{I_BNOV,   F_UOV, 1'b1},
        '{I_BRANCH, F_0,   1'b1}
    };

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_a_n, rst_b_n;
    logic resume_a, resume_b;
    logic halt_a, halt_b, fault_a, fault_b;
    logic [3:0]  cnt_a;
    logic [15:0] cnt_b;
    ctrl_state_t st_a, st_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ks_ctrl_unit_p_if if_a ();
    ks_ctrl_unit_p_if if_b ();

    ks_ctrl_unit_p #(.MEM_HANDSHAKE(1), .WAIT_LIMIT(8), .OV_SIGNED(0), .CNT_W(4)) dut_a (
        .clk         (clk),
        .rst_n       (rst_a_n),
        .bus         (if_a),
        .resume      (resume_a),
        .halt        (halt_a),
        .fault       (fault_a),
        .instr_count (cnt_a),
        .state_dbg   (st_a)
    );

    ks_ctrl_unit_p #(.MEM_HANDSHAKE(0), .WAIT_LIMIT(16), .OV_SIGNED(1), .CNT_W(16)) dut_b (
        .clk         (clk),
        .rst_n       (rst_b_n),
        .bus         (if_b),
        .resume      (resume_b),
        .halt        (halt_b),
        .fault       (fault_b),
        .instr_count (cnt_b),
        .state_dbg   (st_b)
    );

    logic [W-1:0] obs_a, obs_b;
    assign obs_a = {if_a.branch, if_a.pc_enable, if_a.ir_enable, if_a.write_reg_enable,
                    if_a.addr_sel, if_a.c_sel, if_a.flags_reg_enable, if_a.ram_write_enable,
                    if_a.operation, if_a.mem_req, halt_a, fault_a, 12'b0, cnt_a};
    assign obs_b = {if_b.branch, if_b.pc_enable, if_b.ir_enable, if_b.write_reg_enable,
                    if_b.addr_sel, if_b.c_sel, if_b.flags_reg_enable, if_b.ram_write_enable,
                    if_b.operation, if_b.mem_req, halt_b, fault_b, cnt_b};

    // ---------------- scoreboard ----------------
    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];
    logic [W-1:0] e_a, e_b;
    int checks = 0;
    int errors = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (exp_a_q.size() != 0) begin
                e_a = exp_a_q.pop_front();
                checks++;
                if (obs_a !== e_a) begin
                    errors++;
                    $display("FAIL dut_a check %0d (state %s): got ctl=%h count=%0d, expected ctl=%h count=%0d",
                             checks, st_a.name(), obs_a[28:16], obs_a[15:0], e_a[28:16], e_a[15:0]);
                end
            end
            if (exp_b_q.size() != 0) begin
                e_b = exp_b_q.pop_front();
                checks++;
                if (obs_b !== e_b) begin
                    errors++;
                    $display("FAIL dut_b check %0d (state %s): got ctl=%h count=%0d, expected ctl=%h count=%0d",
                             checks, st_b.name(), obs_b[28:16], obs_b[15:0], e_b[28:16], e_b[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive_a(input decoded_instruction_type instr, input logic [3:0] flg,
                           input logic rdy, input logic res, input logic [12:0] ctl, input int cnt);
        if_a.decoded_instruction = instr;
        {if_a.zero_op, if_a.neg_op, if_a.unsigned_overflow, if_a.signed_overflow} = flg;
        if_a.mem_ready = rdy;
        resume_a = res;
        exp_a_q.push_back({ctl, 16'(cnt)});
        @(posedge clk);
        #1;
    endtask

    task automatic drive_b(input decoded_instruction_type instr, input logic [3:0] flg,
                           input logic res, input logic [12:0] ctl, input int cnt);
        if_b.decoded_instruction = instr;
        {if_b.zero_op, if_b.neg_op, if_b.unsigned_overflow, if_b.signed_overflow} = flg;
        resume_b = res;
        exp_b_q.push_back({ctl, 16'(cnt)});
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_b(input int cnt);
        drive_b(I_NOP, F_0, 1'b0, MR | IR | PC, cnt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        resume_a = 1'b0;
        resume_b = 1'b0;
        if_a.decoded_instruction = I_NOP;
        {if_a.zero_op, if_a.neg_op, if_a.unsigned_overflow, if_a.signed_overflow} = F_0;
        if_a.mem_ready = 1'b0;
        if_b.decoded_instruction = I_NOP;
        {if_b.zero_op, if_b.neg_op, if_b.unsigned_overflow, if_b.signed_overflow} = F_0;
        if_b.mem_ready = 1'b0;
        @(posedge clk);
        #1;

        // dut_a: reset state, then release
        drive_a(I_NOP, F_0, 1'b0, 1'b0, MR, 0);
        rst_a_n = 1'b1;

        // LOAD with mem_ready four cycles late
        drive_a(I_NOP,  F_0, 1'b1, 1'b0, MR | IR | PC, 0);
        drive_a(I_LOAD, F_0, 1'b0, 1'b0, NONE, 0);
        for (int i = 0; i < 4; i++) drive_a(I_NOP, F_0, 1'b0, 1'b0, AS | MR, 0);
        drive_a(I_NOP, F_0, 1'b1, 1'b0, AS | MR | WR, 0);

        // FETCH with mem_ready arriving on the 8th waiting cycle: no fault
        for (int i = 0; i < 7; i++) drive_a(I_NOP, F_0, 1'b0, 1'b0, MR, 1);
        drive_a(I_NOP, F_0, 1'b1, 1'b0, MR | IR | PC, 1);
        drive_a(I_NOP, F_0, 1'b0, 1'b0, NONE, 1);

        // FETCH timeout after 8 cycles; FAULT ignores mem_ready and resume
        for (int i = 0; i < 8; i++) drive_a(I_NOP, F_0, 1'b0, 1'b0, MR, 2);
        for (int i = 0; i < 3; i++) drive_a(I_NOP, F_0, 1'b1, 1'b1, HT | FT, 2);
        rst_a_n = 1'b0;
        drive_a(I_NOP, F_0, 1'b0, 1'b0, MR, 0);
        rst_a_n = 1'b1;

        // BOV tests unsigned overflow here: not taken, back in FETCH after 2 cycles
        drive_a(I_NOP, F_0,   1'b1, 1'b0, MR | IR | PC, 0);
        drive_a(I_BOV, F_SOV, 1'b0, 1'b0, NONE, 0);
        drive_a(I_NOP, F_0,   1'b0, 1'b0, MR, 1);
        drive_a(I_NOP, F_0,   1'b1, 1'b0, MR | IR | PC, 1);
        drive_a(I_BNOV, F_SOV, 1'b0, 1'b0, NONE, 1);
        drive_a(I_NOP, F_0,   1'b0, 1'b0, BR | PC | AS, 1);
        rst_a_n = 1'b0;
        drive_a(I_NOP, F_0, 1'b0, 1'b0, MR, 0);
        rst_a_n = 1'b1;

        // 17 NOPs on a 4-bit counter wrap it to 1
        for (int i = 0; i < 17; i++) begin
            drive_a(I_NOP, F_0, 1'b1, 1'b0, MR | IR | PC, i % 16);
            drive_a(I_NOP, F_0, 1'b0, 1'b0, NONE, i % 16);
        end

        // HALT, resume pulse, count unchanged
        drive_a(I_NOP,  F_0, 1'b1, 1'b0, MR | IR | PC, 1);
        drive_a(I_HALT, F_0, 1'b0, 1'b0, NONE, 1);
        drive_a(I_NOP,  F_0, 1'b1, 1'b0, HT, 1);
        drive_a(I_NOP,  F_0, 1'b0, 1'b1, HT, 1);
        drive_a(I_NOP,  F_0, 1'b0, 1'b1, MR, 1);
        drive_a(I_NOP,  F_0, 1'b0, 1'b0, MR, 1);

        // Reset in the middle of a STORE wait, then a complete STORE
        drive_a(I_NOP,   F_0, 1'b1, 1'b0, MR | IR | PC, 1);
        drive_a(I_STORE, F_0, 1'b0, 1'b0, NONE, 1);
        drive_a(I_NOP,   F_0, 1'b0, 1'b0, AS | MR | RW, 1);
        rst_a_n = 1'b0;
        drive_a(I_NOP, F_0, 1'b0, 1'b0, MR, 0);
        rst_a_n = 1'b1;
        drive_a(I_NOP,   F_0, 1'b0, 1'b0, MR, 0);
        drive_a(I_NOP,   F_0, 1'b1, 1'b0, MR | IR | PC, 0);
        drive_a(I_STORE, F_0, 1'b0, 1'b0, NONE, 0);
        drive_a(I_NOP,   F_0, 1'b1, 1'b0, AS | MR | RW, 0);
        drive_a(I_NOP,   F_0, 1'b0, 1'b0, MR, 1);

        // dut_b (no memory handshake): reset state, ADD then HALT
        drive_b(I_NOP, F_0, 1'b0, MR | IR | PC, 0);
        rst_b_n = 1'b1;
        fetch_b(0);
        drive_b(I_ADD,  F_0, 1'b0, OADD | FL, 0);
        drive_b(I_NOP,  F_0, 1'b0, CS | WR | OADD, 0);
        fetch_b(1);
        drive_b(I_HALT, F_0, 1'b0, NONE, 1);
        drive_b(I_NOP,  F_0, 1'b0, HT, 1);
        drive_b(I_NOP,  F_0, 1'b1, HT, 1);

        // ALU ops: write-back uses the latched op, not the current opcode
        fetch_b(1);
        drive_b(I_SUB,  F_0, 1'b0, OSUB | FL, 1);
        drive_b(I_AND,  F_0, 1'b0, CS | WR | OSUB, 1);
        fetch_b(2);
        drive_b(I_AND,  F_0, 1'b0, OAND | FL, 2);
        drive_b(I_OR,   F_0, 1'b0, CS | WR | OAND, 2);
        fetch_b(3);
        drive_b(I_MOVE, F_0, 1'b0, NONE, 3);
        drive_b(I_SUB,  F_0, 1'b0, CS | WR, 3);
        fetch_b(4);
        drive_b(I_OR,   F_0, 1'b0, FL, 4);
        drive_b(I_NOP,  F_0, 1'b0, CS | WR, 4);

        // Branch conditions (overflow tests use signed_overflow here)
        n = 5;
        for (int i = 0; i < 10; i++) begin
            fetch_b(n);
            drive_b(br_tab[i].ins, br_tab[i].flg, 1'b0, NONE, n);
            if (br_tab[i].taken) drive_b(I_NOP, F_0, 1'b0, BR | PC | AS, n);
            n++;
        end

        // LOAD / STORE complete at once without the handshake
        fetch_b(15);
        drive_b(I_LOAD,  F_0, 1'b0, NONE, 15);
        drive_b(I_NOP,   F_0, 1'b0, AS | MR | WR, 15);
        fetch_b(16);
        drive_b(I_STORE, F_0, 1'b0, NONE, 16);
        drive_b(I_NOP,   F_0, 1'b0, AS | MR | RW, 16);
        fetch_b(17);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
